// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
// Two-requester round-robin arbiter in front of a bitwise logic unit
// (AND/OR/XOR/NOR). The single-entry result register is refilled in the
// same cycle it is drained. Per-requester grant counters saturate at all-ones.

module logic_unit_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic [15:0]      grant_cnt0,
   output logic [15:0]      grant_cnt1
);

   // Priority holder: the requester that wins when both are valid
   typedef enum logic [0:0] {
      PRI0 = 1'b0,
      PRI1 = 1'b1
   } pri_state_t;

   pri_state_t       state_r;
   pri_state_t       state_nxt_s;

   logic             can_accept_s;
   logic             grant0_s;
   logic             grant1_s;
   logic [1:0]       op_sel_s;
   logic [WIDTH-1:0] a_sel_s;
   logic [WIDTH-1:0] b_sel_s;
   logic [WIDTH-1:0] result_s;

   logic             rsp_valid_r;
   logic             rsp_id_r;
   logic [WIDTH-1:0] rsp_data_r;
   logic [15:0]      grant_cnt0_r;
   logic [15:0]      grant_cnt1_r;

   // Bitwise operation selected by a 2-bit opcode
   function automatic logic [WIDTH-1:0] logic_op(
      input logic [1:0]       op,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      logic [WIDTH-1:0] r;
      case (op)
         2'b00:   r = a & b;
         2'b01:   r = a | b;
         2'b10:   r = a ^ b;
         2'b11:   r = ~(a | b);
         default: r = {WIDTH{1'b0}};
      endcase
      return r;
   endfunction

   // Saturating 16-bit increment
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      logic [15:0] r;
      if (v == 16'hFFFF) begin
         r = 16'hFFFF;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

   // The buffer can take a new result when empty or when it drains this cycle
   always_comb begin
      can_accept_s = !rsp_valid_r || rsp_ready;
   end

   // Grant selection: single valid requester wins, contention goes to the priority holder
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (can_accept_s) begin
         if (req0_valid && req1_valid) begin
            if (state_r == PRI1) begin
               grant1_s = 1'b1;
            end else begin
               grant0_s = 1'b1;
            end
         end else if (req0_valid) begin
            grant0_s = 1'b1;
         end else if (req1_valid) begin
            grant1_s = 1'b1;
         end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
         end
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   // Readies mirror the grants but are held low while reset is asserted
   always_comb begin
      req0_ready = grant0_s & rst_n;
      req1_ready = grant1_s & rst_n;
   end

   // Priority passes to the other requester after each grant, holds otherwise
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         PRI0: begin
            if (grant0_s) begin
               state_nxt_s = PRI1;
            end else begin
               state_nxt_s = PRI0;
            end
         end
         PRI1: begin
            if (grant1_s) begin
               state_nxt_s = PRI0;
            end else begin
               state_nxt_s = PRI1;
            end
         end
         default: state_nxt_s = PRI0;
      endcase
   end

   // Operand mux toward the logic unit, steered by the winning requester
   always_comb begin
      op_sel_s = req0_op;
      a_sel_s  = req0_a;
      b_sel_s  = req0_b;
      if (grant1_s) begin
         op_sel_s = req1_op;
         a_sel_s  = req1_a;
         b_sel_s  = req1_b;
      end else begin
         op_sel_s = req0_op;
         a_sel_s  = req0_a;
         b_sel_s  = req0_b;
      end
      result_s = logic_op(op_sel_s, a_sel_s, b_sel_s);
   end

   // Round-robin state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= PRI0;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Result register: load on grant, clear on delivery without refill, else hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= 1'b0;
         rsp_data_r  <= {WIDTH{1'b0}};
      end else if (grant0_s || grant1_s) begin
         rsp_valid_r <= 1'b1;
         rsp_id_r    <= grant1_s;
         rsp_data_r  <= result_s;
      end else if (rsp_valid_r && rsp_ready) begin
         rsp_valid_r <= 1'b0;
      end
   end

   // Saturating per-requester grant counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0_r <= 16'd0;
         grant_cnt1_r <= 16'd0;
      end else begin
         if (grant0_s) begin
            grant_cnt0_r <= sat_inc16(grant_cnt0_r);
         end
         if (grant1_s) begin
            grant_cnt1_r <= sat_inc16(grant_cnt1_r);
         end
      end
   end

   // Registered outputs
   always_comb begin
      rsp_valid  = rsp_valid_r;
      rsp_id     = rsp_id_r;
      rsp_data   = rsp_data_r;
      grant_cnt0 = grant_cnt0_r;
      grant_cnt1 = grant_cnt1_r;
   end

endmodule
